clk_div_bank: RTL and testbench

Multi-channel programmable clock-enable/divided-clock generator running from the board reference clock. Produces `NUM_CLOCKS` registered, glitch-free divided outputs with per-channel divide ratio, high time and phase offset, plus a `locked` indicator. Reprogramming is applied to all channels together in a hold/settle sequence. It sits directly downstream of the system PLL and feeds slow peripheral clocks and strobes, so IP cores need no extra PLL outputs.

---
 rtl/clk_div_bank.sv | 178 +++++++++++++++++
 tb/tb_clk_div_bank.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_bank.sv
// Multi-channel programmable divided-clock generator with a HOLD/SETTLE/LOCKED restart sequence.
// Optional feature macro CLK_DIV_BANK_DUTY_EN: honour cfg_high; when undefined, high time is floor(div/2).
module clk_div_bank #(
    parameter int NUM_CLOCKS  = 4,
    parameter int DIV_W       = 16,
    parameter int LOCK_CYCLES = 16,
    parameter int CH_W        = $clog2((NUM_CLOCKS > 2) ? NUM_CLOCKS : 2)
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [DIV_W-1:0]      cfg_div,
    input  logic [DIV_W-1:0]      cfg_high,
    input  logic [DIV_W-1:0]      cfg_phase,
    input  logic                  cfg_commit,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic                  locked
);
    localparam int               LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [DIV_W-1:0] ONE    = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO    = DIV_W'(2);

    typedef enum logic [1:0] {ST_HOLD, ST_SETTLE, ST_LOCKED} state_t;

    state_t            state_q, state_d;
    logic [1:0]        hold_cnt_q, hold_cnt_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              wr_acc, commit, run_start;

    logic [DIV_W-1:0] wr_div, wr_phase;
    logic [DIV_W-1:0] sh_div    [NUM_CLOCKS];
    logic [DIV_W-1:0] sh_phase  [NUM_CLOCKS];
    logic [DIV_W-1:0] act_div   [NUM_CLOCKS];
    logic [DIV_W-1:0] act_phase [NUM_CLOCKS];
    logic [DIV_W-1:0] cnt_q     [NUM_CLOCKS];
    logic [DIV_W-1:0] cnt_nxt   [NUM_CLOCKS];
    logic [DIV_W-1:0] high_eff  [NUM_CLOCKS];

`ifdef CLK_DIV_BANK_DUTY_EN
    logic [DIV_W-1:0] wr_high;
    logic [DIV_W-1:0] sh_high  [NUM_CLOCKS];
    logic [DIV_W-1:0] act_high [NUM_CLOCKS];
`else
    logic unused_cfg_high;
    assign unused_cfg_high = ^cfg_high;
`endif

    // Clamp on the way into shadow so the running counters never see an illegal setting.
    always_comb begin
        wr_div   = (cfg_div < TWO) ? TWO : cfg_div;
        wr_phase = (cfg_phase >= wr_div) ? wr_div - ONE : cfg_phase;
`ifdef CLK_DIV_BANK_DUTY_EN
        wr_high  = (cfg_high > wr_div) ? wr_div : cfg_high;
`endif
    end

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        lock_cnt_d = lock_cnt_q;
        run_start  = 1'b0;
        cfg_ready  = (state_q != ST_HOLD);
        locked     = (state_q == ST_LOCKED);
        wr_acc     = cfg_valid & cfg_ready;
        commit     = wr_acc & cfg_commit;
        case (state_q)
            ST_HOLD: begin
                if (hold_cnt_q == 2'd2) begin
                    state_d    = ST_SETTLE;
                    lock_cnt_d = '0;
                    run_start  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 2'd1;
                end
            end
            ST_SETTLE: begin
                if (commit) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = 2'd1;
                end else if (lock_cnt_q == LOCK_W'(LOCK_CYCLES - 1)) begin
                    state_d = ST_LOCKED;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
            end
            default: begin
                if (commit) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = 2'd1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= 2'd0;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            cnt_nxt[i] = (cnt_q[i] == act_div[i] - ONE) ? '0 : cnt_q[i] + ONE;
`ifdef CLK_DIV_BANK_DUTY_EN
            high_eff[i] = act_high[i];
`else
            high_eff[i] = act_div[i] >> 1;
`endif
        end
    end

    // NOTE: the settings banks are deliberately reset, since the defaults must be live straight out of reset.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                sh_div[i]    <= TWO;
                sh_phase[i]  <= '0;
                act_div[i]   <= TWO;
                act_phase[i] <= '0;
`ifdef CLK_DIV_BANK_DUTY_EN
                sh_high[i]   <= ONE;
                act_high[i]  <= ONE;
`endif
            end
        end else begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                if (wr_acc && cfg_ch == CH_W'(i)) begin
                    sh_div[i]   <= wr_div;
                    sh_phase[i] <= wr_phase;
`ifdef CLK_DIV_BANK_DUTY_EN
                    sh_high[i]  <= wr_high;
`endif
                end
                // Shadow cannot change during HOLD, so copying on every HOLD cycle is safe.
                if (state_q == ST_HOLD) begin
                    act_div[i]   <= sh_div[i];
                    act_phase[i] <= sh_phase[i];
`ifdef CLK_DIV_BANK_DUTY_EN
                    act_high[i]  <= sh_high[i];
`endif
                end
            end
        end
    end

    // Outputs are registered, so a commit truncates a high pulse exactly at a refclk edge.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            outclk <= '0;
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CLOCKS; i++) begin
                if (run_start) begin
                    cnt_q[i]  <= act_phase[i];
                    outclk[i] <= (act_phase[i] < high_eff[i]);
                end else if (state_q == ST_HOLD || commit) begin
                    outclk[i] <= 1'b0;
                end else begin
                    cnt_q[i]  <= cnt_nxt[i];
                    outclk[i] <= (cnt_nxt[i] < high_eff[i]);
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: a cycle-level reference model queues expectations, a monitor compares.
module tb_clk_div_bank;
    localparam int N  = 3;
    localparam int DW = 16;
    localparam int LC = 16;
    localparam int CW = 2;

    logic          refclk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_ch;
    logic [DW-1:0] cfg_div;
    logic [DW-1:0] cfg_high;
    logic [DW-1:0] cfg_phase;
    logic          cfg_commit;
    logic [N-1:0]  outclk;
    logic          locked;

    always #5 refclk = ~refclk;

    clk_div_bank #(.NUM_CLOCKS(N), .DIV_W(DW), .LOCK_CYCLES(LC)) dut (
        .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
        .cfg_commit(cfg_commit), .outclk(outclk), .locked(locked)
    );

    typedef struct {
        logic [N-1:0] out;
        logic         lk;
        logic         rdy;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: settings plus "cycles since HOLD entry" and running index k.
    int sh_div[N], sh_high[N], sh_ph[N];
    int ac_div[N], ac_high[N], ac_ph[N];
    bit m_hold;
    int m_hcyc, m_k;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp, input int at);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, at, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            sh_div[i] = 2; sh_high[i] = 1; sh_ph[i] = 0;
            ac_div[i] = 2; ac_high[i] = 1; ac_ph[i] = 0;
        end
        m_hold = 1'b1;
        m_hcyc = 0;
        m_k    = 0;
    endfunction

    function automatic void model_edge(input bit v, input int ch, input int d, input int h, input int p, input bit c);
        bit wr;
        int dc;
        wr = v && !m_hold;
        if (wr && ch < N) begin
            dc = (d < 2) ? 2 : d;
            sh_div[ch]  = dc;
            sh_high[ch] = h;
            sh_ph[ch]   = (p >= dc) ? dc - 1 : p;
        end
        if (wr && c) begin
            m_hold = 1'b1;
            m_hcyc = 1;
        end else if (m_hold) begin
            if (m_hcyc == 2) begin
                m_hold = 1'b0;
                m_k    = 0;
            end else begin
                m_hcyc++;
            end
        end else begin
            m_k++;
        end
        if (m_hold) begin
            for (int i = 0; i < N; i++) begin
                ac_div[i] = sh_div[i]; ac_high[i] = sh_high[i]; ac_ph[i] = sh_ph[i];
            end
        end
    endfunction

    function automatic logic [N-1:0] model_out();
        logic [N-1:0] o;
        int hi;
        o = '0;
        for (int i = 0; i < N; i++) begin
`ifdef CLK_DIV_BANK_DUTY_EN
            hi = ac_high[i];
`else
            hi = ac_div[i] / 2;
`endif
            if (!m_hold) o[i] = (((ac_ph[i] + m_k) % ac_div[i]) < hi);
        end
        return o;
    endfunction

    task automatic step(input bit v, input int ch, input int d, input int h, input int p, input bit c);
        exp_t e;
        cfg_valid  = v;
        cfg_ch     = CW'(ch);
        cfg_div    = DW'(d);
        cfg_high   = DW'(h);
        cfg_phase  = DW'(p);
        cfg_commit = c;
        @(posedge refclk);
        model_edge(v, ch, d, h, p, c);
        cyc++;
        #1;
        cfg_valid  = 1'b0;
        cfg_commit = 1'b0;
        e.out = model_out();
        e.lk  = !m_hold && (m_k >= LC);
        e.rdy = !m_hold;
        e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge refclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outclk", outclk, e.out, e.cyc);
                check("locked", locked, e.lk, e.cyc);
                check("cfg_ready", cfg_ready, e.rdy, e.cyc);
            end
        end
    end

    initial begin : stim
        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        cfg_high = '0; cfg_phase = '0; cfg_commit = 1'b0;
        model_reset();
        #1;
        check("reset_outclk", outclk, 0, cyc);
        check("reset_locked", locked, 0, cyc);
        check("reset_ready", cfg_ready, 0, cyc);
        repeat (2) @(posedge refclk);
        @(negedge refclk);
        rst = 1'b0;

        // Defaults: refclk/2 on every channel, lock after LC running cycles.
        idle(22);
        // ch1 11000, ch2 00110.
        step(1'b1, 1, 5, 2, 0, 1'b0);
        step(1'b1, 2, 5, 2, 3, 1'b1);
        idle(24);
        // div=7 high=6: duty depends on the feature macro.
        step(1'b1, 0, 7, 6, 0, 1'b1);
        idle(22);
        // Out-of-range channel: data dropped, restart still happens.
        step(1'b1, 3, 9, 4, 1, 1'b1);
        idle(22);
        // Clamps: div 0 -> 2 with high 0, div 3 with high 3.
        step(1'b1, 0, 0, 0, 0, 1'b0);
        step(1'b1, 1, 3, 3, 0, 1'b1);
        idle(10);
        // Commit while ch0 (div 8, high 4) is mid-pulse.
        step(1'b1, 0, 8, 4, 0, 1'b1);
        idle(3);
        step(1'b1, 0, 8, 4, 0, 1'b1);
        idle(6);

        // Asynchronous reset between edges, five cycles into SETTLE.
        @(negedge refclk);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_outclk", outclk, 0, cyc);
        check("async_rst_locked", locked, 0, cyc);
        check("async_rst_ready", cfg_ready, 0, cyc);
        model_reset();
        repeat (2) @(posedge refclk);
        #1;
        check("held_rst_outclk", outclk, 0, cyc);
        @(negedge refclk);
        rst = 1'b0;
        idle(22);

        for (int t = 0; t < 40; t++) begin
            step(1'b1, $urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(0, 12),
                 $urandom_range(0, 12), ($urandom_range(0, 2) == 0));
            idle($urandom_range(0, 25));
        end

        repeat (3) @(negedge refclk);
        check("scoreboard_drained", exp_q.size(), 0, cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
